// File: rtl/prog_out_func_pkg.sv
// prog_out_func_pkg: shared constants and helpers for the programmable
// automaton output-function table.
//   OUT_FUNC_IN_W / OUT_FUNC_OUT_W : default lookup address / entry widths
//   OUT_FUNC_INIT                  : default packed reset table
//   init_entry(init, i, w)         : entry i (w bits wide) of a packed table
package prog_out_func_pkg;

   localparam int unsigned OUT_FUNC_IN_W  = 4;
   localparam int unsigned OUT_FUNC_OUT_W = 4;
   localparam logic [63:0] OUT_FUNC_INIT  = 64'h0448_3072_2d7c_52ac;

   // Widest packed table / entry the helper can slice.
   localparam int unsigned INIT_MAX_W  = 1024;
   localparam int unsigned ENTRY_MAX_W = 32;

   // Returns entry i of a packed table, zero-extended to ENTRY_MAX_W.
   function automatic logic [ENTRY_MAX_W-1:0] init_entry(
      input logic [INIT_MAX_W-1:0] init,
      input int unsigned           i,
      input int unsigned           w = OUT_FUNC_OUT_W
   );
      logic [INIT_MAX_W-1:0] shifted;
      logic [INIT_MAX_W-1:0] mask;
      shifted = init >> (w * i);
      mask    = (INIT_MAX_W'(1) << w) - INIT_MAX_W'(1);
      return ENTRY_MAX_W'(shifted & mask);
   endfunction

endpackage

// File: rtl/prog_out_func_lut_regfile.sv
// lut_regfile: DEPTH x OUT_W register array holding the output-function table.
//   clk, rst_n  : clock, synchronous active-low reset (loads INIT)
//   restore     : one-cycle strobe, reloads the whole array from INIT
//   wr_en/addr/data : single write port (caller has already applied lock)
//   rd_addr     : asynchronous read address
//   rd_data     : read data, reflecting a same-cycle write or restore
module lut_regfile
   import prog_out_func_pkg::*;
#(
   parameter int unsigned AW    = OUT_FUNC_IN_W,
   parameter int unsigned OUT_W = OUT_FUNC_OUT_W,
   parameter logic [(2**AW)*OUT_W-1:0] INIT = OUT_FUNC_INIT
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             restore,
   input  logic             wr_en,
   input  logic [AW-1:0]    wr_addr,
   input  logic [OUT_W-1:0] wr_data,
   input  logic [AW-1:0]    rd_addr,
   output logic [OUT_W-1:0] rd_data
);

   localparam int unsigned DEPTH = 2**AW;
   localparam logic [INIT_MAX_W-1:0] INIT_EXT = INIT_MAX_W'(INIT);

   logic [OUT_W-1:0] init_mem [DEPTH];
   logic [OUT_W-1:0] mem_q    [DEPTH];

   for (genvar g = 0; g < DEPTH; g++) begin : g_init
      assign init_mem[g] = OUT_W'(init_entry(INIT_EXT, unsigned'(g), OUT_W));
   end

   always_ff @(posedge clk) begin
      if (!rst_n || restore) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= init_mem[i];
         end
      end else if (wr_en) begin
         mem_q[wr_addr] <= wr_data;
      end
   end

   // Read returns what the array will hold after this edge, so a registered
   // lookup sees a same-cycle restore or accepted write.
   always_comb begin
      rd_data = mem_q[rd_addr];
      if (restore) begin
         rd_data = init_mem[rd_addr];
      end else if (wr_en && (wr_addr == rd_addr)) begin
         rd_data = wr_data;
      end
   end

endmodule

// File: rtl/prog_out_func.sv
// prog_out_func: programmable output-function LUT with registered lookup.
//   clk, rst_n        : clock, synchronous active-low reset
//   in_valid, in      : lookup request and address
//   out_valid, out    : registered lookup result (out holds when no lookup)
//   wr_en/addr/data   : table write port
//   lock              : level, blocks writes (rejected writes pulse wr_err)
//   restore           : one-cycle strobe, reload table from INIT
//   wr_err            : registered one-cycle pulse for a rejected write
module prog_out_func
   import prog_out_func_pkg::*;
#(
   parameter int unsigned IN_W  = OUT_FUNC_IN_W,
   parameter int unsigned OUT_W = OUT_FUNC_OUT_W,
   parameter logic [(2**IN_W)*OUT_W-1:0] INIT = OUT_FUNC_INIT
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic [IN_W-1:0]  in,
   output logic             out_valid,
   output logic [OUT_W-1:0] out,
   input  logic             wr_en,
   input  logic [IN_W-1:0]  wr_addr,
   input  logic [OUT_W-1:0] wr_data,
   input  logic             lock,
   input  logic             restore,
   output logic             wr_err
);

   logic             wr_accept;
   logic             wr_reject;
   logic [OUT_W-1:0] rd_data;
   logic [OUT_W-1:0] out_q;
   logic             out_valid_q;
   logic             wr_err_q;

   // Restore swallows any same-cycle write, including a locked one.
   assign wr_accept = wr_en && !lock && !restore;
   assign wr_reject = wr_en &&  lock && !restore;

   lut_regfile #(
      .AW    (IN_W),
      .OUT_W (OUT_W),
      .INIT  (INIT)
   ) u_lut (
      .clk     (clk),
      .rst_n   (rst_n),
      .restore (restore),
      .wr_en   (wr_accept),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .rd_addr (in),
      .rd_data (rd_data)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_q       <= '0;
         out_valid_q <= 1'b0;
         wr_err_q    <= 1'b0;
      end else begin
         out_valid_q <= in_valid;
         wr_err_q    <= wr_reject;
         if (in_valid) begin
            out_q <= rd_data;
         end
      end
   end

   assign out       = out_q;
   assign out_valid = out_valid_q;
   assign wr_err    = wr_err_q;

endmodule

// File: tb/tb_prog_out_func.sv
module tb_prog_out_func;

   logic       clk = 1'b0;
   logic       rst_n, in_valid, wr_en, lock, restore;
   logic [3:0] in, wr_addr, wr_data;
   logic       out_valid, wr_err;
   logic [3:0] out;

   // 8-entry x 8-bit variant
   logic       v_rst_n, v_in_valid, v_wr_en, v_lock, v_restore;
   logic [2:0] v_in, v_wr_addr;
   logic [7:0] v_wr_data;
   logic       v_out_valid, v_wr_err;
   logic [7:0] v_out;

   int nvec = 0;
   int nerr = 0;

   logic [3:0] exp_tab [16] = '{4'hc, 4'ha, 4'h2, 4'h5, 4'hc, 4'h7, 4'hd, 4'h2,
                                4'h2, 4'h7, 4'h0, 4'h3, 4'h8, 4'h4, 4'h4, 4'h0};

   always #5 clk = ~clk;

   prog_out_func dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in        (in),
      .out_valid (out_valid),
      .out       (out),
      .wr_en     (wr_en),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .lock      (lock),
      .restore   (restore),
      .wr_err    (wr_err)
   );

   prog_out_func #(
      .IN_W  (3),
      .OUT_W (8),
      .INIT  (64'h8877_6655_4433_2211)
   ) dut8 (
      .clk       (clk),
      .rst_n     (v_rst_n),
      .in_valid  (v_in_valid),
      .in        (v_in),
      .out_valid (v_out_valid),
      .out       (v_out),
      .wr_en     (v_wr_en),
      .wr_addr   (v_wr_addr),
      .wr_data   (v_wr_data),
      .lock      (v_lock),
      .restore   (v_restore),
      .wr_err    (v_wr_err)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
      nvec++;
      assert (got === want) else begin
         nerr++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, want);
      end
   endtask

   initial begin
      rst_n = 0; in_valid = 0; in = 0; wr_en = 0; wr_addr = 0; wr_data = 0;
      lock = 0; restore = 0;
      v_rst_n = 0; v_in_valid = 0; v_in = 0; v_wr_en = 0; v_wr_addr = 0;
      v_wr_data = 0; v_lock = 0; v_restore = 0;
      step();
      step();
      chk("rst_out", 32'(out), 0);
      chk("rst_out_valid", 32'(out_valid), 0);
      chk("rst_wr_err", 32'(wr_err), 0);
      chk("v_rst_out_valid", 32'(v_out_valid), 0);
      rst_n = 1; v_rst_n = 1;

      // Back-to-back sweep of the reset table
      for (int i = 0; i < 16; i++) begin
         in = 4'(i); in_valid = 1;
         step();
         chk($sformatf("sweep_out[%0d]", i), 32'(out), 32'(exp_tab[i]));
         chk($sformatf("sweep_valid[%0d]", i), 32'(out_valid), 1);
      end
      in_valid = 0;
      step();
      chk("idle_valid", 32'(out_valid), 0);
      chk("idle_out_hold", 32'(out), 0);

      // Unlocked write then lookup
      wr_en = 1; wr_addr = 3; wr_data = 4'hf;
      step();
      wr_en = 0;
      chk("wr_ok_err", 32'(wr_err), 0);
      in = 3; in_valid = 1;
      step();
      chk("wr_lookup3", 32'(out), 32'hf);
      in = 4;
      step();
      chk("lookup4", 32'(out), 32'hc);
      in_valid = 0;
      step();
      chk("hold_valid", 32'(out_valid), 0);
      chk("hold_out", 32'(out), 32'hc);

      // Same-cycle write and lookup, unlocked: write-through
      wr_en = 1; wr_addr = 6; wr_data = 4'h1; in = 6; in_valid = 1;
      step();
      chk("wt_out", 32'(out), 32'h1);
      chk("wt_err", 32'(wr_err), 0);
      // Restore entry 6 before the locked repeat
      wr_en = 0; in_valid = 0; restore = 1;
      step();
      restore = 0;
      // Same-cycle write and lookup, locked: old entry, error pulse
      wr_en = 1; lock = 1; in = 6; in_valid = 1;
      step();
      chk("lock_out", 32'(out), 32'hd);
      chk("lock_err", 32'(wr_err), 1);
      wr_en = 0; lock = 0;
      step();
      chk("lock_err_clr", 32'(wr_err), 0);
      chk("lock_out_kept", 32'(out), 32'hd);

      // Write 0 and 15, then restore with a locked write in the same cycle
      in_valid = 0;
      wr_en = 1; wr_addr = 0; wr_data = 4'h9;
      step();
      wr_addr = 15;
      step();
      wr_en = 0; in = 15; in_valid = 1;
      step();
      chk("pre_restore15", 32'(out), 32'h9);
      restore = 1; wr_en = 1; wr_addr = 0; wr_data = 4'h5; lock = 1; in = 0;
      step();
      chk("restore_err", 32'(wr_err), 0);
      chk("restore_lookup0", 32'(out), 32'hc);
      restore = 0; wr_en = 0; lock = 0; in = 15;
      step();
      chk("restore_err_next", 32'(wr_err), 0);
      chk("restore15", 32'(out), 32'h0);
      in = 0;
      step();
      chk("restore0", 32'(out), 32'hc);

      // Mid-stream reset
      in_valid = 0; wr_en = 1; wr_addr = 2; wr_data = 4'he;
      step();
      wr_en = 0; in = 2; in_valid = 1;
      step();
      chk("pre_rst2", 32'(out), 32'he);
      in = 5; rst_n = 0;
      step();
      chk("midrst_out", 32'(out), 0);
      chk("midrst_valid", 32'(out_valid), 0);
      rst_n = 1; in = 2;
      step();
      chk("post_rst2", 32'(out), 32'h2);
      chk("post_rst_valid", 32'(out_valid), 1);
      in = 5;
      step();
      chk("post_rst5", 32'(out), 32'h7);
      in_valid = 0;

      // 8-entry x 8-bit variant
      for (int i = 0; i < 8; i++) begin
         v_in = 3'(i); v_in_valid = 1;
         step();
         chk($sformatf("v_sweep[%0d]", i), 32'(v_out), 32'(8'h11 * (i + 1)));
      end
      v_in_valid = 0; v_wr_en = 1; v_lock = 1; v_wr_addr = 5; v_wr_data = 8'haa;
      step();
      chk("v_lock_err", 32'(v_wr_err), 1);
      v_wr_en = 0; v_lock = 0; v_in = 5; v_in_valid = 1;
      step();
      chk("v_lock_err_clr", 32'(v_wr_err), 0);
      chk("v_lock_kept", 32'(v_out), 32'h66);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
